data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl_if.sv | 33 +++
 rtl/data_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the execute stage and the data memory controller.
//
// Handshake: a request transfers on a rising clk edge where reqValid and
// reqReady are both 1; the requester holds writeEnable/funct3/address/dataIn
// stable while reqValid is 1 and reqReady is 0. respValid is a one-cycle
// pulse with no back-pressure; dataOut and error are meaningful only while
// respValid is 1.
interface data_mem_ctrl_if #(
  parameter int Height = 64,
  parameter int Length = 32
);
  localparam int AW = $clog2(Height) + $clog2(Length / 8);

  logic              reqValid;
  logic              reqReady;
  logic              writeEnable;
  logic [2:0]        funct3;
  logic [AW-1:0]     address;
  logic [Length-1:0] dataIn;
  logic              respValid;
  logic [Length-1:0] dataOut;
  logic              error;

  modport master (
    output reqValid, writeEnable, funct3, address, dataIn,
    input  reqReady, respValid, dataOut, error
  );

  modport slave (
    input  reqValid, writeEnable, funct3, address, dataIn,
    output reqReady, respValid, dataOut, error
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressed data memory for the load/store stage.
// RISC-V B/H/W(/D) accesses with byte-lane stores, sign/zero-extended loads,
// WaitStates extra cycles between accept and response, and illegal-funct3
// error reporting.
// Optional macro DMEM_MISALIGN_CHECK_EN: when defined, an access not aligned
// to its size is rejected with error=1; when undefined, such an access is
// aligned down and completes normally.
module data_mem_ctrl #(
  parameter int Height     = 64,
  parameter int Length     = 32,
  parameter int WaitStates = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus,
  output logic [1:0]     dbgState
);
  localparam int BYTES = Length / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int WB    = $clog2(Height);
  localparam int AW    = WB + LB;
  localparam logic [3:0] CNT_INIT = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       go_resp;

  // Request captured at accept; consumed when the wait phase finishes.
  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [AW-1:0]     lat_addr;
  logic [Length-1:0] lat_data;

  // Access operands: live bus with no wait states, latched copy after WAIT.
  logic              src_we;
  logic [2:0]        src_f3;
  logic [AW-1:0]     src_addr;
  logic [Length-1:0] src_data;

  logic [LB-1:0]     size_mask;
  logic [LB-1:0]     lane;
  logic [WB-1:0]     word_idx;
  logic              legal;
  logic              misaligned;
  logic              bad;
  logic [BYTES-1:0]  byte_en;
  logic [Length-1:0] wr_data;
  logic [Length-1:0] rd_word;
  logic [Length-1:0] rd_shift;
  logic [Length-1:0] load_val;
  logic              mem_we;

  // Zero at power-up; rst_n intentionally leaves the contents alone.
  logic [Length-1:0] mem [Height] = '{default: '0};

  assign accept       = bus.reqValid && bus.reqReady;
  assign bus.reqReady = rst_n && (state_q != WAIT);
  assign bus.respValid = (state_q == RESP);
  assign dbgState     = state_q;

  assign src_we   = (state_q == WAIT) ? lat_we   : bus.writeEnable;
  assign src_f3   = (state_q == WAIT) ? lat_f3   : bus.funct3;
  assign src_addr = (state_q == WAIT) ? lat_addr : bus.address;
  assign src_data = (state_q == WAIT) ? lat_data : bus.dataIn;

  // State and wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; go_resp marks the edge that performs the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (WaitStates == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture request fields on every accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we   <= 1'b0;
      lat_f3   <= 3'd0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      lat_we   <= bus.writeEnable;
      lat_f3   <= bus.funct3;
      lat_addr <= bus.address;
      lat_data <= bus.dataIn;
    end
  end

  // Decode size, legality, byte lanes and the extended load value.
  always_comb begin
    size_mask = LB'((4'd1 << src_f3[1:0]) - 4'd1);
    lane      = src_addr[LB-1:0] & ~size_mask;
    word_idx  = src_addr[AW-1:LB];
    if (src_we) begin
      legal = !src_f3[2] && ((src_f3[1:0] != 2'b11) || (Length == 64));
    end else begin
      legal = (src_f3 != 3'b111) &&
              !(((src_f3 == 3'b011) || (src_f3 == 3'b110)) && (Length == 32));
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = |(src_addr[LB-1:0] & size_mask);
`else
    misaligned = 1'b0;
`endif
    bad = !legal || misaligned;
    for (int b = 0; b < BYTES; b++) begin
      byte_en[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << src_f3[1:0]));
    end
    wr_data  = src_data << {lane, 3'b000};
    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (src_f3)
      3'b000:  load_val = Length'($signed(rd_shift[7:0]));
      3'b001:  load_val = Length'($signed(rd_shift[15:0]));
      3'b010:  load_val = Length'($signed(rd_shift[31:0]));
      3'b011:  load_val = rd_shift;
      3'b100:  load_val = Length'(rd_shift[7:0]);
      3'b101:  load_val = Length'(rd_shift[15:0]);
      3'b110:  load_val = Length'(rd_shift[31:0]);
      default: load_val = '0;
    endcase
    mem_we = go_resp && src_we && !bad;
  end

  // Byte-lane store; unselected bytes keep their value.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Response fields, loaded on the edge entering RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dataOut <= '0;
      bus.error   <= 1'b0;
    end else if (go_resp) begin
      bus.error   <= bad;
      bus.dataOut <= (bad || src_we) ? '0 : load_val;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (WaitStates 0, 3, 2) sharing one
// request driver, a byte-array reference model with an expected queue, a
// vector table for the directed load/store sequence and hand-written timing
// and reset sequences.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [7:0]  addr = 8'd0;
  logic [31:0] din = 32'd0;
  int          sel = 0;

  logic        cur_ready, cur_rsp, cur_err;
  logic [31:0] cur_dout;
  logic [1:0]  dbg0, dbg1, dbg2;

  int checks = 0;
  int errors = 0;
  int ws_of [3] = '{0, 3, 2};

  logic [7:0]  mm [3][256];
  logic [32:0] exp_q [$];

  typedef struct {
    logic        w;
    logic [2:0]  f;
    logic [7:0]  a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;
  vec_t vt [18];

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.Height(64), .Length(32)) bus0 ();
  data_mem_ctrl_if #(.Height(64), .Length(32)) bus1 ();
  data_mem_ctrl_if #(.Height(64), .Length(32)) bus2 ();

  assign bus0.reqValid = req_valid && (sel == 0);
  assign bus1.reqValid = req_valid && (sel == 1);
  assign bus2.reqValid = req_valid && (sel == 2);
  assign bus0.writeEnable = we;   assign bus1.writeEnable = we;   assign bus2.writeEnable = we;
  assign bus0.funct3 = f3;        assign bus1.funct3 = f3;        assign bus2.funct3 = f3;
  assign bus0.address = addr;     assign bus1.address = addr;     assign bus2.address = addr;
  assign bus0.dataIn = din;       assign bus1.dataIn = din;       assign bus2.dataIn = din;

  data_mem_ctrl #(.Height(64), .Length(32), .WaitStates(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .dbgState(dbg0));
  data_mem_ctrl #(.Height(64), .Length(32), .WaitStates(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbgState(dbg1));
  data_mem_ctrl #(.Height(64), .Length(32), .WaitStates(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .dbgState(dbg2));

  always_comb begin
    case (sel)
      1: begin cur_ready = bus1.reqReady; cur_rsp = bus1.respValid; cur_err = bus1.error; cur_dout = bus1.dataOut; end
      2: begin cur_ready = bus2.reqReady; cur_rsp = bus2.respValid; cur_err = bus2.error; cur_dout = bus2.dataOut; end
      default: begin cur_ready = bus0.reqReady; cur_rsp = bus0.respValid; cur_err = bus0.error; cur_dout = bus0.dataOut; end
    endcase
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: memory as bytes; returns {error, dataOut}.
  function automatic logic [32:0] model_access(input int s, input logic w, input logic [2:0] f,
                                               input int a, input logic [31:0] d);
    int n;
    int base;
    bit legal;
    bit mis;
    logic [63:0] v;
    n = 1 << f[1:0];
    if (w) legal = (f[2] == 1'b0) && (f[1:0] != 2'b11);
    else   legal = (f != 3'b011) && (f != 3'b110) && (f != 3'b111);
    base = a - (a % n);
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (a % n) != 0;
`else
    mis = 1'b0;
`endif
    if (!legal || mis) return {1'b1, 32'h0};
    if (w) begin
      for (int i = 0; i < n; i++) mm[s][base + i] = d[8*i +: 8];
      return 33'h0;
    end
    v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(mm[s][base + i]) << (8 * i));
    if (!f[2] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return {1'b0, v[31:0]};
  endfunction

  // One request: drive, wait for ready, count cycles until respValid.
  task automatic xact(input int s, input logic w, input logic [2:0] f, input logic [7:0] a,
                      input logic [31:0] d, output int lat, output logic e, output logic [31:0] q);
    int t;
    sel = s; we = w; f3 = f; addr = a; din = d; req_valid = 1'b1;
    #1;
    t = 0;
    while (!cur_ready && t < 40) begin @(negedge clk); t++; end
    if (!cur_ready) begin
      checks++; errors++;
      $display("FAIL xact_ready got=0 exp=1");
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!cur_rsp && lat < 40) begin @(negedge clk); lat++; end
    e = cur_err;
    q = cur_dout;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic e;
    logic [31:0] q;
    logic [32:0] x;
    logic [32:0] b2b [3];
    int er [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    int ev [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    for (int s = 0; s < 3; s++) for (int i = 0; i < 256; i++) mm[s][i] = 8'h00;

    vt[0]  = '{1'b1, 3'b010, 8'h08, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 3'b010, 8'h08, 32'h0, 1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 3'b000, 8'h09, 32'h0000007F, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 3'b000, 8'h09, 32'h0, 1'b0, 32'h0000007F};
    vt[4]  = '{1'b0, 3'b010, 8'h08, 32'h0, 1'b0, 32'hDEAD7FEF};
    vt[5]  = '{1'b0, 3'b100, 8'h0B, 32'h0, 1'b0, 32'h000000DE};
    vt[6]  = '{1'b0, 3'b001, 8'h0A, 32'h0, 1'b0, 32'hFFFFDEAD};
`ifdef DMEM_MISALIGN_CHECK_EN
    vt[7]  = '{1'b0, 3'b010, 8'h0A, 32'h0, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 3'b001, 8'h09, 32'h00001234, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 3'b010, 8'h08, 32'h0, 1'b0, 32'hDEAD7FEF};
    vt[17] = '{1'b0, 3'b000, 8'h08, 32'h0, 1'b0, 32'hFFFFFFEF};
`else
    vt[7]  = '{1'b0, 3'b010, 8'h0A, 32'h0, 1'b0, 32'hDEAD7FEF};
    vt[8]  = '{1'b1, 3'b001, 8'h09, 32'h00001234, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 3'b010, 8'h08, 32'h0, 1'b0, 32'hDEAD1234};
    vt[17] = '{1'b0, 3'b000, 8'h08, 32'h0, 1'b0, 32'h00000034};
`endif
    vt[10] = '{1'b0, 3'b011, 8'h08, 32'h0, 1'b1, 32'h0};
    vt[11] = '{1'b1, 3'b100, 8'h08, 32'hFFFFFFFF, 1'b1, 32'h0};
    vt[12] = '{1'b0, 3'b010, 8'h08, 32'h0, 1'b0, vt[9].e_data};
    vt[13] = '{1'b0, 3'b110, 8'h08, 32'h0, 1'b1, 32'h0};
    vt[14] = '{1'b0, 3'b111, 8'h08, 32'h0, 1'b1, 32'h0};
    vt[15] = '{1'b1, 3'b111, 8'h08, 32'hFFFFFFFF, 1'b1, 32'h0};
    vt[16] = '{1'b0, 3'b101, 8'h0A, 32'h0, 1'b0, 32'h0000DEAD};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", cur_ready, 0);
    check("rst_resp", cur_rsp, 0);
    check("rst_dout", cur_dout, 0);
    check("rst_err", cur_err, 0);
    check("rst_state", {dbg0, dbg1, dbg2}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", cur_ready, 1);

    // Directed vectors on WaitStates=0
    for (int i = 0; i < 18; i++) begin
      x = model_access(0, vt[i].w, vt[i].f, int'(vt[i].a), vt[i].d);
      xact(0, vt[i].w, vt[i].f, vt[i].a, vt[i].d, lat, e, q);
      check($sformatf("vec%0d_lat", i), lat, 1);
      check($sformatf("vec%0d_err", i), e, vt[i].e_err);
      check($sformatf("vec%0d_data", i), q, vt[i].e_data);
    end

    // Back-to-back loads at one per cycle
    b2b[0] = model_access(0, 1'b0, 3'b010, 8, 0);
    b2b[1] = model_access(0, 1'b0, 3'b101, 10, 0);
    b2b[2] = model_access(0, 1'b0, 3'b100, 11, 0);
    sel = 0; we = 1'b0; f3 = 3'b010; addr = 8'h08; req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_resp", k), cur_rsp, 1);
      check($sformatf("b2b%0d_data", k), cur_dout, b2b[k-1][31:0]);
      if (k == 1) begin f3 = 3'b101; addr = 8'h0A; end
      else if (k == 2) begin f3 = 3'b100; addr = 8'h0B; end
      else req_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_pulse_end", cur_rsp, 0);

    // WaitStates=3 timing with a request pending during WAIT
    x = model_access(1, 1'b1, 3'b010, 0, 32'h11112222);
    xact(1, 1'b1, 3'b010, 8'h00, 32'h11112222, lat, e, q);
    check("ws3_store_lat", lat, 4);
    x = model_access(1, 1'b1, 3'b010, 4, 32'h33334444);
    xact(1, 1'b1, 3'b010, 8'h04, 32'h33334444, lat, e, q);
    check("ws3_store2_lat", lat, 4);
    we = 1'b0; f3 = 3'b010; addr = 8'h00; req_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check($sformatf("ws3_c%0d_ready", n), cur_ready, er[n]);
      check($sformatf("ws3_c%0d_resp", n), cur_rsp, ev[n]);
      if (n == 4) check("ws3_first_data", cur_dout, 32'h11112222);
      if (n == 8) check("ws3_second_data", cur_dout, 32'h33334444);
      if (n == 1) addr = 8'h04;
      if (n == 5) req_valid = 1'b0;
    end

    // Randomized traffic on WaitStates 0 and 3
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 40; k++) begin
        logic        rw;
        logic [2:0]  rf;
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [32:0] ex;
        rw = 1'($urandom_range(0, 1));
        rf = 3'($urandom_range(0, 7));
        ra = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
        rd = $urandom;
        exp_q.push_back(model_access(s, rw, rf, int'(ra), rd));
        xact(s, rw, rf, ra, rd, lat, e, q);
        ex = exp_q.pop_front();
        check($sformatf("rnd%0d_%0d_lat", s, k), lat, ws_of[s] + 1);
        check($sformatf("rnd%0d_%0d_err", s, k), e, ex[32]);
        check($sformatf("rnd%0d_%0d_data", s, k), q, ex[31:0]);
      end
    end

    // Reset during WAIT drops the latched store
    @(negedge clk);
    sel = 2; we = 1'b1; f3 = 3'b010; addr = 8'h10; din = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_wait_ready", cur_ready, 0);
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("rstmid_resp%0d", n), cur_rsp, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    x = model_access(2, 1'b0, 3'b010, 16, 0);
    xact(2, 1'b0, 3'b010, 8'h10, 32'h0, lat, e, q);
    check("rstmid_lat", lat, 3);
    check("rstmid_err", e, x[32]);
    check("rstmid_data", q, x[31:0]);

    // Randomized traffic on WaitStates 2
    for (int k = 0; k < 30; k++) begin
      logic        rw;
      logic [2:0]  rf;
      logic [7:0]  ra;
      logic [31:0] rd;
      logic [32:0] ex;
      rw = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 31));
      rd = $urandom;
      exp_q.push_back(model_access(2, rw, rf, int'(ra), rd));
      xact(2, rw, rf, ra, rd, lat, e, q);
      ex = exp_q.pop_front();
      check($sformatf("rnd2_%0d_lat", k), lat, 3);
      check($sformatf("rnd2_%0d_err", k), e, ex[32]);
      check($sformatf("rnd2_%0d_data", k), q, ex[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
